// File: rtl/wishbone_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : wishbone_arbiter_pkg
// Brief  : Shared state encoding and limits for the Wishbone arbiter.
// Rev    : 1.0
// ============================================================================
package wishbone_arbiter_pkg;

    localparam int MAX_MASTERS = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wishbone_interface.sv
`default_nettype none
// ============================================================================
// Module : wishbone_interface
// Brief  : Classic Wishbone bus bundle with master/slave views.
// Rev    : 1.0
// ============================================================================
interface wishbone_interface;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_mosi;
    logic [31:0] dat_miso;
    logic [3:0]  sel;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, adr, dat_mosi, sel,
        input  dat_miso, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_mosi, sel,
        output dat_miso, ack, err
    );

endinterface
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module : rr_picker
// Brief  : Combinational winner select; round-robin after last_owner, or
//          lowest-index-wins when WB_ARBITER_FIXED_PRIORITY_EN is defined.
// Rev    : 1.0
// ============================================================================
module rr_picker
    import wishbone_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_owner,
    output logic [NUM_MASTERS-1:0] winner
);

    logic found;

`ifdef WB_ARBITER_FIXED_PRIORITY_EN
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`else
    // First pass covers indices above last_owner, second pass wraps around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i] && (i > int'(last_owner))) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i] && (i <= int'(last_owner))) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/wishbone_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wishbone_arbiter
// Brief  : N-master to one-slave Wishbone arbiter, non-preemptive, with
//          combinational routing; WB_ARBITER_FIXED_PRIORITY_EN selects
//          fixed priority instead of round-robin.
// Rev    : 1.0
// ============================================================================
module wishbone_arbiter
    import wishbone_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    wishbone_interface.slave       masters [NUM_MASTERS],
    wishbone_interface.master      slave,
    output logic [NUM_MASTERS-1:0] grant
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_t             state;
    logic [IDX_W-1:0]       last_owner;
    logic [IDX_W-1:0]       owner_idx;
    logic [IDX_W-1:0]       pick_base;
    logic                   owner_cyc;
    logic [NUM_MASTERS-1:0] winner;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] stb_v;
    logic [NUM_MASTERS-1:0] we_v;
    logic [31:0]            adr_v [NUM_MASTERS];
    logic [31:0]            dat_v [NUM_MASTERS];
    logic [3:0]             sel_v [NUM_MASTERS];

    logic                   route_cyc;
    logic                   route_stb;
    logic                   route_we;
    logic [31:0]            route_adr;
    logic [31:0]            route_dat;
    logic [3:0]             route_sel;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
        assign req[i]   = masters[i].cyc;
        assign stb_v[i] = masters[i].stb;
        assign we_v[i]  = masters[i].we;
        assign adr_v[i] = masters[i].adr;
        assign dat_v[i] = masters[i].dat_mosi;
        assign sel_v[i] = masters[i].sel;

        assign masters[i].ack      = grant[i] & slave.ack;
        assign masters[i].err      = grant[i] & slave.err;
        assign masters[i].dat_miso = grant[i] ? slave.dat_miso : 32'h0;
    end

    // Grant is one-hot or zero, so a priority-free OR-style mux is exact.
    always_comb begin
        route_cyc = 1'b0;
        route_stb = 1'b0;
        route_we  = 1'b0;
        route_adr = 32'h0;
        route_dat = 32'h0;
        route_sel = 4'h0;
        owner_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                route_cyc = req[i];
                route_stb = stb_v[i];
                route_we  = we_v[i];
                route_adr = adr_v[i];
                route_dat = dat_v[i];
                route_sel = sel_v[i];
                owner_idx = IDX_W'(i);
            end
        end
    end

    assign slave.cyc      = route_cyc;
    assign slave.stb      = route_stb;
    assign slave.we       = route_we;
    assign slave.adr      = route_adr;
    assign slave.dat_mosi = route_dat;
    assign slave.sel      = route_sel;

    assign owner_cyc = |(grant & req);

    // On a release the departing owner becomes the new round-robin base.
    assign pick_base = (state == ARB_OWNED) ? owner_idx : last_owner;

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req        (req),
        .last_owner (pick_base),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_owner <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        state <= ARB_OWNED;
                        grant <= winner;
                    end
                end
                ARB_OWNED: begin
                    if (!owner_cyc) begin
                        last_owner <= owner_idx;
                        if (|req) begin
                            grant <= winner;
                        end else begin
                            grant <= '0;
                            state <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wishbone_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_wishbone_arbiter
// Brief  : Self-checking bench for wishbone_arbiter (3 masters).
// Rev    : 1.0
// ============================================================================
module tb_wishbone_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] m_cyc = '0;
    logic [N-1:0] m_stb = '0;
    logic [N-1:0] m_we  = '0;
    logic [31:0]  m_adr [N];
    logic [31:0]  m_dat [N];
    logic [3:0]   m_sel [N];
    logic [N-1:0] r_ack;
    logic [N-1:0] r_err;
    logic [31:0]  r_dat [N];
    logic         s_ack = 1'b0;
    logic         s_err = 1'b0;
    logic [31:0]  s_dat = 32'h0;
    logic [N-1:0] grant;

    int total = 0;
    int bad   = 0;

    wishbone_interface m_if [N] ();
    wishbone_interface s_if ();

    for (genvar g = 0; g < N; g++) begin : g_m
        assign m_if[g].cyc      = m_cyc[g];
        assign m_if[g].stb      = m_stb[g];
        assign m_if[g].we       = m_we[g];
        assign m_if[g].adr      = m_adr[g];
        assign m_if[g].dat_mosi = m_dat[g];
        assign m_if[g].sel      = m_sel[g];
        assign r_ack[g]         = m_if[g].ack;
        assign r_err[g]         = m_if[g].err;
        assign r_dat[g]         = m_if[g].dat_miso;
    end

    assign s_if.ack      = s_ack;
    assign s_if.err      = s_err;
    assign s_if.dat_miso = s_dat;

    wishbone_arbiter #(.NUM_MASTERS(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .masters (m_if),
        .slave   (s_if),
        .grant   (grant)
    );

    // ---------------- reference model: owner index, -1 when idle ----------
    int owner = -1;
    int last  = N - 1;

    function automatic int pick(input logic [N-1:0] r, input int prev);
        logic [2*N-1:0] dbl;
        int start;
`ifdef WB_ARBITER_FIXED_PRIORITY_EN
        start = 0;
`else
        start = (prev + 1) % N;
`endif
        dbl = {r, r} >> start;
        for (int k = 0; k < N; k++)
            if (dbl[k]) return (start + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= -1;
            last  <= N - 1;
        end else if (owner < 0) begin
            if (m_cyc != '0) owner <= pick(m_cyc, last);
        end else if (m_cyc[owner] == 1'b0) begin
            last  <= owner;
            owner <= pick(m_cyc, owner);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        logic [N-1:0] eg;
        logic [70:0]  es;
        logic [33:0]  er;
        @(negedge clk);
        eg = '0;
        es = '0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            es = {m_cyc[owner], m_stb[owner], m_we[owner], m_sel[owner], m_adr[owner], m_dat[owner]};
        end
        chk("model_grant", 128'(grant), 128'(eg));
        chk("model_slave_side",
            128'({s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.adr, s_if.dat_mosi}), 128'(es));
        for (int i = 0; i < N; i++) begin
            er = (i == owner) ? {s_ack, s_err, s_dat} : 34'h0;
            chk($sformatf("model_master%0d_return", i), 128'({r_ack[i], r_err[i], r_dat[i]}), 128'(er));
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic req_set(input int i, input logic v);
        m_cyc[i] = v;
        m_stb[i] = v;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        s_ack = 1'b0;
        s_err = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    function automatic int grant_idx();
        for (int i = 0; i < N; i++)
            if (grant[i]) return i;
        return -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fair_exp [6];
        int own;
        logic [N-1:0] idle_exp [4];
`ifdef WB_ARBITER_FIXED_PRIORITY_EN
        fair_exp = '{0, 1, 0, 1, 0, 1};
        idle_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        fair_exp = '{0, 1, 2, 0, 1, 2};
        idle_exp = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
        for (int i = 0; i < N; i++) begin
            m_adr[i] = 32'hA000_0000 + 32'(i) * 32'h0000_1100;
            m_dat[i] = 32'h5500_0000 + 32'(i) * 32'h0001_0001;
            m_sel[i] = 4'(i + 5);
        end
        m_we = 3'b101;
        #1 rst = 1'b0;
        do_reset();
        chk("reset_grant", 128'(grant), 128'(0));
        chk("reset_slave_cyc", 128'(s_if.cyc), 128'(0));

        // Single request: master1, ack in cycle 3.
        req_set(1, 1'b1);
        step();
        chk("single_grant", 128'(grant), 128'(3'b010));
        chk("single_slave_cyc", 128'(s_if.cyc), 128'(1));
        chk("single_slave_adr", 128'(s_if.adr), 128'(32'hA000_1100));
        step();
        chk("single_no_ack_c2", 128'(r_ack), 128'(0));
        step();
        s_ack = 1'b1;
        s_dat = 32'h1234_5678;
        #1;
        chk("single_ack_c3", 128'(r_ack), 128'(3'b010));
        chk("single_dat_c3", 128'(r_dat[1]), 128'(32'h1234_5678));
        step();
        s_ack = 1'b0;
        req_set(1, 1'b0);
        #1;
        chk("single_ack_gone", 128'(r_ack), 128'(0));
        step();
        chk("single_idle", 128'(grant), 128'(0));

        // Contention: 0 and 1 together, handoff with no idle cycle.
        do_reset();
        req_set(0, 1'b1);
        req_set(1, 1'b1);
        step();
        chk("cont_first", 128'(grant), 128'(3'b001));
        s_ack = 1'b1;
        s_err = 1'b1;
        s_dat = 32'hDEAD_0001;
        step();
        s_ack = 1'b0;
        s_err = 1'b0;
        req_set(0, 1'b0);
        #1;
        chk("cont_release_cyc_low", 128'(s_if.cyc), 128'(0));
        step();
        chk("cont_handoff", 128'(grant), 128'(3'b010));
        req_set(1, 1'b0);
        step(2);

        // Fairness: all held high, one ack per tenure.
        do_reset();
        for (int i = 0; i < N; i++) req_set(i, 1'b1);
        step();
        for (int t = 0; t < 6; t++) begin
            own = grant_idx();
            chk($sformatf("fair_order_%0d", t), 128'(own), 128'(fair_exp[t]));
            if (own < 0) own = 0;
            s_ack = 1'b1;
            s_dat = 32'hF000_0000 + 32'(t);
            step();
            s_ack = 1'b0;
            req_set(own, 1'b0);
            step();
            req_set(own, 1'b1);
        end
        m_cyc = '0;
        m_stb = '0;
        step(2);

        // No preemption: master0 holds for 10 acks while master1 waits.
        do_reset();
        req_set(0, 1'b1);
        step();
        req_set(1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            s_ack = 1'b1;
            s_dat = 32'hBEE0_0000 + 32'(k);
            #1;
            chk($sformatf("nopre_grant_%0d", k), 128'(grant), 128'(3'b001));
            chk($sformatf("nopre_m1_ack_%0d", k), 128'(r_ack[1]), 128'(0));
            step();
        end
        s_ack = 1'b0;
        req_set(0, 1'b0);
        step();
        chk("nopre_then_m1", 128'(grant), 128'(3'b010));
        req_set(1, 1'b0);
        step(2);

        // Repeated tenures from IDLE with 0 and 1 requesting together.
        do_reset();
        for (int t = 0; t < 4; t++) begin
            req_set(0, 1'b1);
            req_set(1, 1'b1);
            step();
            chk($sformatf("idle_tenure_%0d", t), 128'(grant), 128'(idle_exp[t]));
            s_ack = 1'b1;
            step();
            s_ack = 1'b0;
            req_set(0, 1'b0);
            req_set(1, 1'b0);
            step();
            chk($sformatf("idle_gap_%0d", t), 128'(grant), 128'(0));
            step();
        end

        // Mid-transaction reset; round-robin base must return to master0.
        do_reset();
        req_set(0, 1'b1);
        step();
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        req_set(0, 1'b0);
        step();
        req_set(1, 1'b1);
        step();
        chk("mrst_m1_owned", 128'(grant), 128'(3'b010));
        step();
        #1 rst = 1'b0;
        #1;
        chk("mrst_grant_drop", 128'(grant), 128'(0));
        chk("mrst_cyc_drop", 128'({s_if.cyc, s_if.stb}), 128'(0));
        req_set(0, 1'b1);
        step();
        chk("mrst_held", 128'(grant), 128'(0));
        rst = 1'b1;
        #1;
        chk("mrst_no_early_grant", 128'(grant), 128'(0));
        step();
        chk("mrst_m0_first", 128'(grant), 128'(3'b001));
        m_cyc = '0;
        m_stb = '0;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesting Wishbone masters, legal range 2..8.
REQ-002 SHALL have ports in this order:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- masters  wishbone_interface.slave  array [NUM_MASTERS]  requester ports
- slave  wishbone_interface.master  1  shared downstream port feeding wishbone_interconnect
- grant  output  NUM_MASTERS  one-hot current owner, all-zero when idle
REQ-003 Bundle signals SHALL be cyc, stb, we (1 bit); adr, dat_mosi, dat_miso (32 bits); sel (4 bits); ack, err (1 bit).
REQ-004 The block SHALL have one clock, with reset asynchronous and active-low.

Function
REQ-005 SHALL implement a two-state FSM:
- IDLE: no owner, grant=0.
- OWNED: grant one-hot.
REQ-006 In IDLE, at a rising edge with any masters[i].cyc=1, SHALL register the winner and enter OWNED.
- Arbitration latency: cyc sampled at edge n, so slave.cyc=1 from cycle n+1.
REQ-007 Winner selection SHALL be round-robin.
- Search starts at index (last_owner+1) mod NUM_MASTERS, ascending with wrap-around.
- last_owner resets to NUM_MASTERS-1, so master 0 has first priority.
REQ-008 In OWNED, routing SHALL be combinational from the grant register:
- slave.{cyc,stb,adr,sel,we,dat_mosi} = owner's signals.
- Owner's {dat_miso,ack,err} = slave's signals.
REQ-009 Non-owners SHALL see ack=0 and err=0; dat_miso SHALL be driven 0.
REQ-010 While OWNED, grant SHALL NOT change while owner cyc=1, regardless of other requests (no preemption mid-cycle).
REQ-011 When owner cyc=0 is sampled at an edge, the block SHALL:
- update last_owner to the released index;
- if another master's cyc=1 at the same edge, grant it directly (OWNED->OWNED, zero idle cycles);
- otherwise go to IDLE.
REQ-012 With owner cyc=0, slave.cyc and slave.stb SHALL be 0 in that same cycle, since routing is combinational.
REQ-013 A released master that re-asserts cyc at the release edge SHALL lose to any other requester, and win only if alone.
REQ-014 In IDLE, all slave outputs SHALL be 0, and all masters SHALL see ack=0, err=0, dat_miso=0.
REQ-015 The block SHALL add no latency to ack/err/dat_miso, and SHALL NOT generate err itself (timeout/decode errors remain downstream).

Reset
REQ-016 When rst=0, SHALL asynchronously force: state IDLE, grant=0, last_owner=NUM_MASTERS-1, slave.cyc=0, slave.stb=0, all masters ack=0 and err=0.
REQ-017 Reset asserted mid-transaction SHALL drop slave.cyc immediately; no transaction state survives.
REQ-018 After rst rises, the first grant SHALL occur no earlier than the first rising edge with rst=1.

Configuration
REQ-019 With macro WB_ARBITER_FIXED_PRIORITY_EN defined, selection SHALL be fixed priority:
- lowest index with cyc=1 wins; last_owner is ignored;
- REQ-013 does not apply.
REQ-020 Without WB_ARBITER_FIXED_PRIORITY_EN, round-robin per REQ-007 SHALL apply.

Structure
REQ-021 Package wishbone_arbiter_pkg SHALL hold:
- state enum (ARB_IDLE, ARB_OWNED);
- constant MAX_MASTERS=8.
REQ-022 Winner selection SHALL be a combinational sub-module rr_picker, with inputs req vector and last_owner, and output one-hot winner.
- The fixed-priority variant is selected inside it.

Verification
REQ-023 Bench SHALL cover these scenarios:
- Single request: master1 cyc=stb=1 at edge 0, slave ack at cycle 3 -> slave.cyc=1 from cycle 1; master1 ack=1 in cycle 3 only; grant=2'b10.
- Contention: masters 0 and 1 assert cyc at the same edge after reset -> master0 granted; on its cyc drop, master1 granted at that same edge, with no IDLE cycle between.
- Fairness, NUM_MASTERS=3, all cyc held high, each tenure one ack -> grant order 0,1,2,0,1,2.
- No preemption: master0 holds cyc for 10 acks while master1 requests -> grant stays 3'b001 for all 10; master1 ack=0 throughout.
- Mid-transaction reset: rst=0 while OWNED with stb=1 -> slave.cyc=0 and grant=0 before the next edge; after release, master0 wins first.
- FIXED_PRIORITY_EN: masters 0 and 1 request continuously -> master0 re-granted every tenure; master1 is never granted.
